// File: rtl/segment_display_scanner_if.sv
// Display update handshake: a new hex value plus decimal points offered to the scanner.
interface segment_display_scanner_if #(
  parameter int DIGITS = 4
);
  logic                  update_valid;
  logic                  update_ready;
  logic [4*DIGITS-1:0]   update_value;
  logic [DIGITS-1:0]     update_dots;

  modport master (output update_valid, update_value, update_dots, input update_ready);
  modport slave  (input update_valid, update_value, update_dots, output update_ready);
endinterface

// File: rtl/segment_display_scanner.sv
// Multiplexed hex 7-segment scanner with dead-time gaps, blanking, leading-zero
// suppression and a single pending buffer that swaps in only at frame boundaries.
//
// state | meaning
// IDLE  | display dark, waiting for enable
// DRIVE | one digit lit for PRESCALE cycles
// GAP   | all anodes off for GAP_CYCLES cycles before the next digit
module segment_display_scanner #(
  parameter int DIGITS     = 4,
  parameter int PRESCALE   = 50000,
  parameter int GAP_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [DIGITS-1:0]         blank_mask,
  input  logic                      lz_enable,
  segment_display_scanner_if.slave  upd,
  output logic [DIGITS-1:0]         anodes,
  output logic [6:0]                segments,
  output logic                      dot,
  output logic                      frame_start
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  localparam int CMAX = (PRESCALE > GAP_CYCLES) ? PRESCALE : GAP_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int DW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CW-1:0] DRIVE_LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [DW-1:0] DIG_LAST   = DW'(DIGITS - 1);

  logic [1:0]          state, nxt_state;
  logic [DW-1:0]       digit, nxt_digit;
  logic [CW-1:0]       cnt, nxt_cnt;
  logic                boundary;
  logic [4*DIGITS-1:0] act_val, act_val_nxt, pend_val;
  logic [DIGITS-1:0]   act_dots, act_dots_nxt, pend_dots;
  logic                pend_full, move_pend;
  logic [DIGITS-1:0]   lz_zero;
  logic                dark;
  logic [DIGITS-1:0]   an_nxt;
  logic [6:0]          seg_nxt;
  logic                dot_nxt;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  always_comb begin
    nxt_state = state;
    nxt_digit = digit;
    nxt_cnt   = cnt;
    boundary  = 1'b0;
    if (state == S_IDLE) begin
      if (enable) begin
        nxt_state = S_DRIVE;
        nxt_digit = '0;
        nxt_cnt   = '0;
        boundary  = 1'b1;
      end
    end else if (!enable) begin
      nxt_state = S_IDLE;
      nxt_digit = '0;
      nxt_cnt   = '0;
    end else if (state == S_DRIVE) begin
      if (cnt == DRIVE_LAST) begin
        nxt_cnt = '0;
        if (GAP_CYCLES > 0) begin
          nxt_state = S_GAP;
        end else begin
          nxt_digit = (digit == DIG_LAST) ? '0 : digit + 1'b1;
          boundary  = (digit == DIG_LAST);
        end
      end else begin
        nxt_cnt = cnt + 1'b1;
      end
    end else begin
      if (cnt == GAP_LAST) begin
        nxt_state = S_DRIVE;
        nxt_cnt   = '0;
        nxt_digit = (digit == DIG_LAST) ? '0 : digit + 1'b1;
        boundary  = (digit == DIG_LAST);
      end else begin
        nxt_cnt = cnt + 1'b1;
      end
    end
  end

  // Pending value lands immediately while idle, otherwise only on a frame boundary.
  assign move_pend        = pend_full && ((state == S_IDLE) || boundary);
  assign act_val_nxt      = move_pend ? pend_val  : act_val;
  assign act_dots_nxt     = move_pend ? pend_dots : act_dots;
  assign upd.update_ready = ~pend_full;

  always_comb begin
    for (int k = 0; k < DIGITS; k++) begin
      lz_zero[k] = ((act_val_nxt >> (4 * k)) == '0);
    end
  end

  // Outputs are computed from the next state so the registers line up with it.
  always_comb begin
    an_nxt  = '1;
    seg_nxt = 7'h7F;
    dot_nxt = 1'b1;
    dark    = blank_mask[nxt_digit] | (lz_enable && (nxt_digit != '0) && lz_zero[nxt_digit]);
    if ((nxt_state == S_DRIVE) && !dark) begin
      an_nxt[nxt_digit] = 1'b0;
      seg_nxt           = hex7(act_val_nxt[nxt_digit*4 +: 4]);
      dot_nxt           = ~act_dots_nxt[nxt_digit];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      digit       <= '0;
      cnt         <= '0;
      act_val     <= '0;
      act_dots    <= '0;
      pend_val    <= '0;
      pend_dots   <= '0;
      pend_full   <= 1'b0;
      anodes      <= '1;
      segments    <= 7'h7F;
      dot         <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      state       <= nxt_state;
      digit       <= nxt_digit;
      cnt         <= nxt_cnt;
      act_val     <= act_val_nxt;
      act_dots    <= act_dots_nxt;
      anodes      <= an_nxt;
      segments    <= seg_nxt;
      dot         <= dot_nxt;
      frame_start <= boundary;
      if (move_pend) begin
        pend_full <= 1'b0;
      end else if (upd.update_valid && !pend_full) begin
        pend_full <= 1'b1;
        pend_val  <= upd.update_value;
        pend_dots <= upd.update_dots;
      end
    end
  end

endmodule

// File: tb/tb_segment_display_scanner.sv
// Bench for segment_display_scanner with DIGITS=4, PRESCALE=4, GAP_CYCLES=1.
module tb_segment_display_scanner;

  typedef struct {
    logic [15:0] val;
    logic [3:0]  dots;
    logic [3:0]  blank;
    logic        lz;
    logic [3:0]  dark;
    logic [27:0] segs;   // {d3,d2,d1,d0} active-low codes
  } row_t;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dot;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [3:0] blank = 4'h0;
  logic       lz = 1'b0;
  logic [3:0] anodes;
  logic [6:0] segments;
  logic       dot;
  logic       frame_start;

  int checks = 0;
  int failures = 0;
  exp_t sb[$];
  row_t rows[7];

  segment_display_scanner_if #(.DIGITS(4)) bus();

  segment_display_scanner #(.DIGITS(4), .PRESCALE(4), .GAP_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .enable(enable), .blank_mask(blank), .lz_enable(lz),
    .upd(bus), .anodes(anodes), .segments(segments), .dot(dot), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push_row(input row_t r);
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      e.an  = r.dark[k] ? 4'hF : ~(4'b0001 << k);
      e.seg = r.segs[k*7 +: 7];
      e.dot = r.dark[k] ? 1'b1 : ~r.dots[k];
      sb.push_back(e);
    end
  endtask

  task automatic offer(input row_t r);
    bit got = 0;
    blank = r.blank;
    lz    = r.lz;
    bus.update_value = r.val;
    bus.update_dots  = r.dots;
    bus.update_valid = 1'b1;
    push_row(r);
    for (int n = 0; n < 50 && !got; n++) begin
      if (bus.update_ready) got = 1;
      else @(negedge clk);
    end
    if (!got) chk("offer_timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
    bus.update_valid = 1'b0;
  endtask

  task automatic wait_frame();
    bit seen = 0;
    @(negedge clk);
    for (int n = 0; n < 40 && !seen; n++) begin
      if (frame_start) seen = 1;
      else @(negedge clk);
    end
    if (!seen) chk("frame_timeout", 0, 1);
  endtask

  task automatic check_frame();
    exp_t e;
    chk("frame_start_at_frame", frame_start, 1);
    for (int k = 0; k < 4; k++) begin
      if (sb.size() == 0) begin
        chk("scoreboard_empty", 0, 1);
        return;
      end
      e = sb.pop_front();
      for (int c = 0; c < 4; c++) begin
        chk($sformatf("d%0d_c%0d_anodes", k, c), anodes, e.an);
        chk($sformatf("d%0d_c%0d_segments", k, c), segments, e.seg);
        chk($sformatf("d%0d_c%0d_dot", k, c), dot, e.dot);
        @(negedge clk);
      end
      chk($sformatf("gap%0d_anodes", k), anodes, 4'hF);
      @(negedge clk);
    end
  endtask

  initial begin
    row_t zero_row;
    rows[0] = '{16'h1234, 4'h0, 4'h0, 1'b0, 4'b0000, {7'h79, 7'h24, 7'h30, 7'h19}};
    rows[1] = '{16'hABCD, 4'h0, 4'h0, 1'b0, 4'b0000, {7'h08, 7'h03, 7'h46, 7'h21}};
    rows[2] = '{16'h0005, 4'h0, 4'h0, 1'b1, 4'b1110, {7'h7F, 7'h7F, 7'h7F, 7'h12}};
    rows[3] = '{16'h0000, 4'h0, 4'h0, 1'b1, 4'b1110, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
    rows[4] = '{16'h5678, 4'b0001, 4'b0010, 1'b0, 4'b0010, {7'h12, 7'h02, 7'h7F, 7'h00}};
    rows[5] = '{16'h9EF0, 4'b1111, 4'h0, 1'b1, 4'b0000, {7'h10, 7'h06, 7'h0E, 7'h40}};
    rows[6] = '{16'h0070, 4'b0110, 4'h0, 1'b1, 4'b1100, {7'h7F, 7'h7F, 7'h78, 7'h40}};
    zero_row = '{16'h0000, 4'h0, 4'h0, 1'b0, 4'b0000, {7'h40, 7'h40, 7'h40, 7'h40}};

    bus.update_valid = 1'b0;
    bus.update_value = '0;
    bus.update_dots  = '0;

    repeat (3) @(negedge clk);
    chk("rst_anodes", anodes, 4'hF);
    chk("rst_segments", segments, 7'h7F);
    chk("rst_dot", dot, 1);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_ready", bus.update_ready, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_anodes", anodes, 4'hF);

    // Load in IDLE: pending drains to active on the following edge.
    offer(rows[0]);
    chk("idle_ready_after_capture", bus.update_ready, 0);
    @(negedge clk);
    chk("idle_ready_after_move", bus.update_ready, 1);
    enable = 1'b1;
    wait_frame();
    check_frame();
    chk("frame_period_20", frame_start, 1);

    for (int i = 1; i < 7; i++) begin
      offer(rows[i]);
      chk($sformatf("row%0d_ready_pending", i), bus.update_ready, 0);
      wait_frame();
      check_frame();
    end

    // Mid-frame update plus an ignored second offer while pending is full.
    offer(rows[0]);
    wait_frame();
    check_frame();
    repeat (6) @(negedge clk);
    offer(rows[1]);
    bus.update_value = 16'h5555;
    bus.update_dots  = 4'hF;
    bus.update_valid = 1'b1;
    chk("midframe_ready_low", bus.update_ready, 0);
    repeat (3) @(negedge clk);
    bus.update_valid = 1'b0;
    chk("midframe_old_d2_anodes", anodes, 4'b1011);
    chk("midframe_old_d2_segments", segments, 7'h24);
    chk("midframe_ready_still_low", bus.update_ready, 0);
    wait_frame();
    check_frame();
    chk("ready_after_boundary", bus.update_ready, 1);

    // Enable dropped during digit 2, then re-enabled.
    repeat (10) @(negedge clk);
    chk("pre_drop_d2_anodes", anodes, 4'b1011);
    enable = 1'b0;
    @(negedge clk);
    chk("drop_anodes", anodes, 4'hF);
    chk("drop_segments", segments, 7'h7F);
    chk("drop_dot", dot, 1);
    enable = 1'b1;
    @(negedge clk);
    chk("reenable_frame_start", frame_start, 1);
    chk("reenable_anodes", anodes, 4'b1110);
    chk("reenable_segments", segments, 7'h21);

    // Reset asserted in the gap after digit 0.
    repeat (4) @(negedge clk);
    chk("gap_anodes", anodes, 4'hF);
    rst = 1'b1;
    #1;
    chk("rst_gap_anodes", anodes, 4'hF);
    chk("rst_gap_segments", segments, 7'h7F);
    chk("rst_gap_frame_start", frame_start, 0);
    chk("rst_gap_ready", bus.update_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    push_row(zero_row);
    @(negedge clk);
    check_frame();

    // Asynchronous reset during a lit digit darkens outputs before any edge.
    @(negedge clk);
    chk("pre_async_anodes", anodes, 4'b1110);
    rst = 1'b1;
    #1;
    chk("rst_async_anodes", anodes, 4'hF);
    chk("rst_async_segments", segments, 7'h7F);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_async_frame_start", frame_start, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/segment_display_scanner.md
SEGMENT_DISPLAY_SCANNER -- requirements
Module: segment_display_scanner

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of multiplexed hex digits (range 1..8).
REQ-002 SHALL have parameter PRESCALE, default 50000, clock cycles each digit is driven (>=1).
REQ-003 SHALL have parameter GAP_CYCLES, default 16, all-anodes-off dead time between digits (>=0).
REQ-004 Clock  input  1  single clock; all state on rising edge.
REQ-005 Reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-006 Enable  input  1  1 = scan display; 0 = display dark.
REQ-007 UpdateValid  input  1  new display value offered.
REQ-008 UpdateReady  output  1  pending buffer empty, value accepted this cycle if UpdateValid.
REQ-009 UpdateValue  input  4*DIGITS  nibble k = digit k, digit 0 rightmost.
REQ-010 UpdateDots  input  DIGITS  decimal point per digit, captured with UpdateValue.
REQ-011 BlankMask  input  DIGITS  bit k=1 forces digit k dark; sampled live, not buffered.
REQ-012 LzEnable  input  1  leading-zero suppression; sampled live.
REQ-013 Anodes  output  DIGITS  active-low digit select, registered.
REQ-014 Segments  output  7  active-low segments {g,f,e,d,c,b,a}, registered.
REQ-015 Dot  output  1  active-low decimal point, registered.
REQ-016 FrameStart  output  1  one-cycle pulse when digit 0 begins a new frame.

Function
REQ-017 SHALL implement FSM states IDLE, DRIVE, GAP; 3-bit-or-less encoding free.
REQ-018 IDLE: Anodes all 1, Segments 7F, Dot 1; Enable=1 -> DRIVE at digit 0, prescaler 0, FrameStart pulse.
REQ-019 DRIVE: prescaler counts 0..PRESCALE-1; at PRESCALE-1 -> GAP if GAP_CYCLES>0, else directly next digit in DRIVE.
REQ-020 GAP: Anodes all 1 for exactly GAP_CYCLES cycles, then DRIVE on next digit, prescaler 0.
REQ-021 Digit index SHALL wrap DIGITS-1 -> 0; entering DRIVE on digit 0 after wrap is a frame boundary and pulses FrameStart.
REQ-022 In DRIVE on digit k: Anodes = all 1 except bit k = 0; Segments = hex code of active nibble k; Dot = ~activeDot[k].
REQ-023 Hex codes (hex, active-low): 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 B:03 C:46 D:21 E:06 F:0E.
REQ-024 Digit k blanked (BlankMask[k]=1 or LZ-suppressed): Anodes all 1, Segments 7F, Dot 1, timing unchanged.
REQ-025 LZ suppression: with LzEnable=1, digit k>0 suppressed when nibbles k..DIGITS-1 of active value all zero; digit 0 never suppressed; dot of suppressed digit also off.
REQ-026 Handshake: transfer when UpdateValid & UpdateReady; value+dots stored in single pending buffer; UpdateReady = ~pendingFull (combinational from register).
REQ-027 In DRIVE/GAP, pending buffer SHALL move to active registers only at a frame boundary (same edge FrameStart asserts); UpdateReady returns 1 the cycle after.
REQ-028 In IDLE, pending buffer SHALL move to active the cycle after capture; active value never changes mid-frame.
REQ-029 UpdateValid while UpdateReady=0 SHALL be ignored; offerer holds value.
REQ-030 Enable falling in DRIVE/GAP: next edge -> IDLE, outputs dark, digit index and prescaler cleared; pending buffer retained.
REQ-031 Enable held high SHALL produce continuous frames of DIGITS*(PRESCALE+GAP_CYCLES) cycles.

Reset
REQ-032 Reset SHALL force: state IDLE, Anodes all 1, Segments 7F, Dot 1, FrameStart 0, UpdateReady 1, active value 0, active dots 0, pending empty, counters 0.
REQ-033 Reset deassert with Enable=1 SHALL start scan at digit 0 on first edge after deassert.

Verification (DIGITS=4, PRESCALE=4, GAP_CYCLES=1)
REQ-034 Reset, Enable=1, value 0x1234 loaded in IDLE -> digit0 anode 1110 Segments 19 for 4 cycles, 1 gap cycle 1111, digit1 Segments 30; FrameStart every 20 cycles.
REQ-035 Mid-frame update 0xABCD while scanning 0x1234 -> remaining digits still show 1234 codes; UpdateReady 0 until boundary; next frame digit0 Segments 21.
REQ-036 Second UpdateValid while pending full -> ignored; only first value appears next frame.
REQ-037 Value 0x0005, LzEnable=1 -> digits 1..3 dark (Anodes 1111), digit0 Segments 12; value 0x0000 -> digit0 shows 40.
REQ-038 BlankMask=0010 with dots 0001 -> digit1 dark for its 4 cycles, digit0 Dot=0, others Dot=1.
REQ-039 Enable dropped during digit2 -> next cycle outputs dark, IDLE; re-enable -> digit0 with FrameStart; Reset asserted mid-GAP -> outputs dark same cycle, active value 0.
